// File: rtl/mio_wb_decoder.sv
// mio_wb_decoder: single-master Wishbone-style address decoder for up to 8 slave slots.
// Each access is latched, decoded to one slot (lowest index wins on overlap), strobed for
// one cycle, then held until the slave reports ready. The access is then acked, or flagged
// as an error when no slot matches.
// Optional feature: define MIO_WB_TIMEOUT_EN to bound the wait phase to TO_CYCLES cycles.
// A slave that has not responded by then gets an error ack.
module mio_wb_decoder #(
    parameter int NSLV = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE =
        {32'h00000000, 32'hFFFFD000, 32'hFFFFFE00, 32'hFFFFFF00},
    parameter logic [NSLV*32-1:0] SLV_MASK =
        {32'hFFFF0000, 32'hFFFFF000, 32'hFFFFFF00, 32'hFFFFFF00},
    parameter int TO_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    // master side
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_i,
    input  logic              we_i,
    input  logic              stb_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic              err_o,
    // slave side
    output logic [NSLV-1:0]   slv_sel_o,
    output logic [NSLV-1:0]   slv_we_o,
    output logic [NSLV-1:0]   slv_rd_o,
    output logic [31:0]       slv_adr_o,
    output logic [31:0]       slv_dat_o,
    input  logic [NSLV*32-1:0] slv_dat_i,
    input  logic [NSLV-1:0]   slv_rdy_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // Elaboration-time sanity checks on the configuration.
    if (NSLV < 1 || NSLV > 8) begin : g_bad_nslv
        $error("mio_wb_decoder: NSLV must be in 1..8");
    end
    if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to
        $error("mio_wb_decoder: TO_CYCLES must be in 1..255");
    end

    logic [2:0]      state_q, state_d;
    logic [NSLV-1:0] sel_oh_q;
    logic            we_q;
    logic [NSLV-1:0] hit_oh;
    logic            hit;
    logic            rdy_hit;
    logic [31:0]     rd_data;
    logic            latch;
    logic            cap_rd;
    logic            clr_dat;

`ifdef MIO_WB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TO_CYCLES);
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    assign cnt_inc = cnt_q + 8'd1;
`endif

    // Address decode: scan high to low so the lowest matching slot is the one left standing.
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if ((adr_i & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) begin
                hit_oh    = '0;
                hit_oh[k] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // Ready and read data of the currently selected slot.
    always_comb begin
        rdy_hit = |(slv_rdy_i & sel_oh_q);
        rd_data = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (sel_oh_q[k]) rd_data = slv_dat_i[k*32 +: 32];
        end
    end

    // Next-state logic; an early strobe drop aborts silently before any wait/ready handling.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        cap_rd  = 1'b0;
        clr_dat = 1'b0;
`ifdef MIO_WB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (stb_i) begin
                    latch = 1'b1;
                    if (hit) begin
                        state_d = S_REQ;
`ifdef MIO_WB_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        state_d = S_ERR;
                        clr_dat = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (!stb_i) begin
                    state_d = S_IDLE;
                end else if (rdy_hit) begin
                    state_d = S_ACK;
                    cap_rd  = ~we_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!stb_i) begin
                    state_d = S_IDLE;
                end else if (rdy_hit) begin
                    // Ready wins even on the cycle the timeout would fire.
                    state_d = S_ACK;
                    cap_rd  = ~we_q;
                end
`ifdef MIO_WB_TIMEOUT_EN
                else if (cnt_inc == TO_LIM) begin
                    state_d = S_ERR;
                    clr_dat = 1'b1;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d   = cnt_inc;
                end
`endif
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_oh_q  <= '0;
            we_q      <= 1'b0;
            slv_adr_o <= '0;
            slv_dat_o <= '0;
            dat_o     <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                slv_adr_o <= adr_i;
                slv_dat_o <= dat_i;
                we_q      <= we_i;
                sel_oh_q  <= hit_oh;
            end
            if (cap_rd) begin
                dat_o <= rd_data;
            end else if (clr_dat) begin
                dat_o <= '0;
            end
        end
    end

`ifdef MIO_WB_TIMEOUT_EN
    // Wait-phase cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Outputs decoded from state; all are zero in IDLE, so reset clears them immediately.
    always_comb begin
        ack_o     = (state_q == S_ACK) || (state_q == S_ERR);
        err_o     = (state_q == S_ERR);
        slv_sel_o = ((state_q == S_REQ) || (state_q == S_WAIT)) ? sel_oh_q : '0;
        slv_we_o  = ((state_q == S_REQ) && we_q) ? sel_oh_q : '0;
        slv_rd_o  = ((state_q == S_REQ) && !we_q) ? sel_oh_q : '0;
    end

endmodule

// File: doc/mio_wb_decoder.md
MIO_WB_DECODER -- requirements
Module: mio_wb_decoder

Interface
REQ-001 The block SHALL have parameter NSLV, default 4: number of slave slots (1..8).
REQ-002 The block SHALL have parameter SLV_BASE [NSLV*32-1:0], default {32'h00000000, 32'hFFFFD000, 32'hFFFFFE00, 32'hFFFFFF00}: base address per slot, slot 0 in the LSBs.
REQ-003 The block SHALL have parameter SLV_MASK [NSLV*32-1:0], default {32'hFFFF0000, 32'hFFFFF000, 32'hFFFFFF00, 32'hFFFFFF00}: compare mask per slot.
REQ-004 The block SHALL have parameter TO_CYCLES, default 15: wait-state timeout limit.
REQ-005 The block SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset), with one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have master ports adr_i (in, 32), dat_i (in, 32), we_i (in, 1), stb_i (in, 1), dat_o (out, 32, read data), ack_o (out, 1), err_o (out, 1).
REQ-007 The block SHALL have slave ports slv_sel_o (out, NSLV, selected slot, held for the whole access), slv_we_o (out, NSLV, one-cycle write strobe), slv_rd_o (out, NSLV, one-cycle read strobe), slv_adr_o (out, 32), slv_dat_o (out, 32), slv_dat_i (in, NSLV*32), slv_rdy_i (in, NSLV, slave done).

Function
REQ-008 Slot k SHALL match when (adr & SLV_MASK[k]) == SLV_BASE[k], and on overlapping matches the lowest index SHALL win.
REQ-009 The FSM SHALL use the states IDLE, REQ, WAIT, ACK and ERR.
REQ-010 In IDLE, when stb_i=1 at a clock edge, the block SHALL latch adr_i, dat_i and we_i into slv_adr_o, slv_dat_o and an internal we register, and SHALL go to REQ if a slot matches, otherwise to ERR.
REQ-011 In REQ, for one cycle, the block SHALL set slv_sel_o[k]=1 and either slv_we_o[k]=we or slv_rd_o[k]=~we.
REQ-012 At the REQ edge the block SHALL go to ACK if slv_rdy_i[k]=1, otherwise to WAIT.
REQ-013 In WAIT, slv_sel_o[k] SHALL stay 1 and the strobes SHALL be 0.
REQ-014 In WAIT, the block SHALL go to ACK on slv_rdy_i[k]=1.
REQ-015 On entry to ACK for a read, dat_o SHALL capture slv_dat_i[k*32+:32].
REQ-016 On a write, dat_o SHALL hold its previous value.
REQ-017 ack_o SHALL be 1 only in ACK and ERR, for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-018 err_o SHALL be 1 only in ERR, and ERR SHALL set dat_o=0.
REQ-019 With zero-wait slaves, ack_o SHALL assert in the second cycle after stb_i is sampled.
REQ-020 An unmapped access SHALL assert ack_o and err_o in the first cycle after stb_i is sampled.
REQ-021 If stb_i=0 in REQ or WAIT, the block SHALL abort to IDLE with no ack_o or err_o, and slv_sel_o SHALL clear at the next edge.
REQ-022 stb_i=1 in the cycle after ACK or ERR SHALL be treated as a new transaction (back-to-back), with no idle cycle inserted.
REQ-023 Inputs adr_i, dat_i and we_i changing after the latch SHALL NOT affect the current access.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, dat_o=0, ack_o=0, err_o=0, all slv_* outputs=0 and the timeout counter=0.
REQ-025 A reset in mid-access SHALL drop the access silently, and the first stb_i after release SHALL start a clean transaction.

Configuration
REQ-026 With macro MIO_WB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry and increment each WAIT cycle.
REQ-027 With MIO_WB_TIMEOUT_EN defined, on reaching TO_CYCLES without slv_rdy_i[k], the FSM SHALL go to ERR (ack_o=1, err_o=1, dat_o=0) and drop slv_sel_o.
REQ-028 With MIO_WB_TIMEOUT_EN defined, slv_rdy_i arriving in the same cycle the counter hits TO_CYCLES SHALL take priority, giving a normal ACK.
REQ-029 Without MIO_WB_TIMEOUT_EN, WAIT SHALL be unbounded, the counter SHALL be absent, and err_o SHALL assert only for unmapped addresses.

Verification
REQ-030 Read FFFFFF00 with slv_rdy_i[0] tied 1 and slv_dat_i slot0=32'h0000A5C3 -> slv_rd_o[0] pulses once, ack_o in cycle 2, dat_o=0000A5C3, err_o=0.
REQ-031 Write 32'h12345678 to FFFFFE04 -> slv_we_o[1] one cycle, slv_dat_o=12345678, slv_adr_o=FFFFFE04, single ack_o.
REQ-032 Read 80000000 (unmapped) -> ack_o=err_o=1 in cycle 1, dat_o=0, all slv_sel_o=0.
REQ-033 Read FFFFD010 with slv_rdy_i[2] raised after 5 cycles -> slv_sel_o[2] held for 6 cycles, ack_o one cycle after rdy.
REQ-034 With MIO_WB_TIMEOUT_EN, read slot 3 with rdy never raised -> ERR after 15 WAIT cycles.
REQ-035 Without MIO_WB_TIMEOUT_EN, read slot 3 with rdy never raised -> remains in WAIT with no ack_o.
REQ-036 Assert rst mid-WAIT, then drop stb_i in WAIT -> all outputs 0 immediately, no ack_o, and the next read completes normally.
